score_bcd_display: RTL

- Consumer end of the game controller's score/life outputs; feeds the seven-segment / on-screen digit renderers.
- Converts the binary score into five registered BCD digits using a sequential double-dabble, one bit per clock.
- Converts life into two BCD digits.
- Re-converts automatically whenever score differs from the last converted value; the last completed result is held stable on the outputs while a conversion runs.

---
 rtl/score_bcd_display.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/score_bcd_display.sv
// Score-to-BCD converter (sequential double-dabble, one bit per clock) plus life-to-BCD.
// Optional macro SCORE_LEADING_ZERO_BLANK_EN replaces leading zero digits with BLANK_CODE.
module score_bcd_display #(
  parameter int         SCORE_W    = 16,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [SCORE_W-1:0] score,
  input  logic [3:0]         life,
  output logic [19:0]        digits,
  output logic [3:0]         life_tens,
  output logic [3:0]         life_ones,
  output logic               busy,
  output logic               update_done
);

  localparam int BCD_W = 20;
  localparam int SR_W  = BCD_W + SCORE_W;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCORE_W - 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t             state;
  state_t             state_next;
  logic [SCORE_W-1:0] last_score;
  logic [SR_W-1:0]    sr;
  logic [SR_W-1:0]    sr_step;
  logic [CNT_W-1:0]   cnt;
  logic               capture;
  logic               step;
  logic               finish;
  logic [BCD_W-1:0]   digits_load;
  logic [3:0]         tens_next;
  logic [3:0]         ones_next;

  // One double-dabble step: adjust every BCD nibble >= 5 by +3, then shift left.
  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] r;
    r = v;
    for (int i = 0; i < 5; i++) begin
      if (r[SCORE_W + 4*i +: 4] >= 4'd5)
        r[SCORE_W + 4*i +: 4] = r[SCORE_W + 4*i +: 4] + 4'd3;
    end
    return {r[SR_W-2:0], 1'b0};
  endfunction

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    logic             lead;
    r    = d;
    lead = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (lead && (d[4*i +: 4] == 4'd0))
        r[4*i +: 4] = BLANK_CODE;
      else
        lead = 1'b0;
    end
    return r;
  endfunction
`endif

  assign sr_step = dabble(sr);

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  assign digits_load = blank_leading(sr_step[SR_W-1 -: BCD_W]);
  assign tens_next   = (life >= 4'd10) ? 4'd1 : BLANK_CODE;
`else
  assign digits_load = sr_step[SR_W-1 -: BCD_W];
  assign tens_next   = (life >= 4'd10) ? 4'd1 : 4'd0;
`endif
  assign ones_next = (life >= 4'd10) ? (life - 4'd10) : life;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (score != last_score) begin
          capture    = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        step = 1'b1;
        if (cnt == LAST_CNT) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Conversion datapath; digits only changes on the final step so it stays stable mid-run.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      last_score  <= '0;
      sr          <= '0;
      cnt         <= '0;
      digits      <= '0;
      busy        <= 1'b0;
      update_done <= 1'b0;
    end else begin
      update_done <= finish;
      if (capture) begin
        last_score <= score;
        sr         <= {{BCD_W{1'b0}}, score};
        cnt        <= '0;
        busy       <= 1'b1;
      end else if (step) begin
        sr  <= sr_step;
        cnt <= cnt + 1'b1;
        if (finish) begin
          digits <= digits_load;
          busy   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      life_tens <= 4'd0;
      life_ones <= 4'd0;
    end else begin
      life_tens <= tens_next;
      life_ones <= ones_next;
    end
  end

endmodule
